// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD MM:SS countdown timer with load/start/pause/expiry control.
// Digits decrement once per 1 Hz tick while running, borrowing down the chain
// so -> st -> mo -> mt. Reaching 00:00 and taking one more tick moves to DONE.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   tick                         one-cycle count enable
//   start_pause                  one-pulse run/pause toggle
//   load                         one-pulse load of load_* digits (clamped)
//   load_mt/mo/st/so [3:0]       values to load
//   mt/mo/st/so [3:0]            current digits (registered)
//   running                      high while in RUN
//   expired                      high while in DONE
//   done_pulse                   one-cycle pulse on RUN->DONE
module bcd_countdown_timer #(
  parameter logic [3:0] INIT_MT = 4'd0,
  parameter logic [3:0] INIT_MO = 4'd1,
  parameter logic [3:0] INIT_ST = 4'd0,
  parameter logic [3:0] INIT_SO = 4'd0,
  parameter logic [3:0] MAX_MT  = 4'd9,
  parameter logic [3:0] MAX_ST  = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_pause,
  input  logic       load,
  input  logic [3:0] load_mt,
  input  logic [3:0] load_mo,
  input  logic [3:0] load_st,
  input  logic [3:0] load_so,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       running,
  output logic       expired,
  output logic       done_pulse
);

  localparam logic [3:0] MAX_ONES = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] mt_next, mo_next, st_next, so_next;
  logic       done_pulse_next;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

  // One BCD digit step: wrap 0 -> max with borrow, otherwise decrement.
  function automatic logic [4:0] dec_digit(input logic [3:0] v, input logic [3:0] max,
                                           input logic en);
    logic [4:0] r;
    r = {1'b0, v};
    if (en) begin
      if (v == 4'd0) r = {1'b1, max};
      else           r = {1'b0, 4'(v - 4'd1)};
    end
    return r;
  endfunction

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mt         <= INIT_MT;
      mo         <= INIT_MO;
      st         <= INIT_ST;
      so         <= INIT_SO;
      running    <= 1'b0;
      expired    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      mt         <= mt_next;
      mo         <= mo_next;
      st         <= st_next;
      so         <= so_next;
      running    <= (state_next == RUN);
      expired    <= (state_next == DONE);
      done_pulse <= done_pulse_next;
    end
  end

  // Next-state, digit borrow chain and pulse generation
  always_comb begin
    logic       all_zero;
    logic       run_tick;
    logic [4:0] so_r, st_r, mo_r, mt_r;

    state_next      = state;
    mt_next         = mt;
    mo_next         = mo;
    st_next         = st;
    so_next         = so;
    done_pulse_next = 1'b0;

    all_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
    run_tick = (state == RUN) && tick;

    // Chain is gated off at 00:00 so the terminal tick holds instead of wrapping.
    so_r = dec_digit(so, MAX_ONES, run_tick && !all_zero);
    st_r = dec_digit(st, MAX_ST,   so_r[4]);
    mo_r = dec_digit(mo, MAX_ONES, st_r[4]);
    mt_r = dec_digit(mt, MAX_MT,   mo_r[4]);

    if (load) begin
      mt_next    = clamp(load_mt, MAX_MT);
      mo_next    = clamp(load_mo, MAX_ONES);
      st_next    = clamp(load_st, MAX_ST);
      so_next    = clamp(load_so, MAX_ONES);
      state_next = IDLE;
    end else begin
      mt_next = mt_r[3:0];
      mo_next = mo_r[3:0];
      st_next = st_r[3:0];
      so_next = so_r[3:0];

      // Expiry wins over a coincident pause request.
      if (run_tick && all_zero) begin
        state_next      = DONE;
        done_pulse_next = 1'b1;
      end else if (start_pause) begin
        case (state)
          IDLE:    state_next = all_zero ? IDLE : RUN;
          RUN:     state_next = PAUSE;
          PAUSE:   state_next = RUN;
          default: state_next = state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: load, countdown, borrow, pause,
// clamp/priority, start-on-zero and asynchronous reset.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, start_pause, load;
  logic [3:0] load_mt, load_mo, load_st, load_so;
  logic [3:0] mt, mo, st, so;
  logic       running, expired, done_pulse;

  int checks = 0;
  int errors = 0;

  bcd_countdown_timer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .start_pause (start_pause),
    .load        (load),
    .load_mt     (load_mt),
    .load_mo     (load_mo),
    .load_st     (load_st),
    .load_so     (load_so),
    .mt          (mt),
    .mo          (mo),
    .st          (st),
    .so          (so),
    .running     (running),
    .expired     (expired),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, sample 1 time unit after the edge.
  task automatic step(input logic l, input logic sp, input logic tk,
                      input logic [15:0] val);
    @(negedge clk);
    load        = l;
    start_pause = sp;
    tick        = tk;
    {load_mt, load_mo, load_st, load_so} = val;
    @(posedge clk);
    #1;
    load        = 1'b0;
    start_pause = 1'b0;
    tick        = 1'b0;
  endtask

  task automatic chk_digits(input string tag, input logic [15:0] exp_v);
    logic [15:0] obs;
    obs = {mt, mo, st, so};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Flags packed as {running, expired, done_pulse}.
  task automatic chk_flags(input string tag, input logic [2:0] exp_v);
    logic [2:0] obs;
    obs = {running, expired, done_pulse};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 1'b0; start_pause = 1'b0; load = 1'b0;
    {load_mt, load_mo, load_st, load_so} = 16'h0;
    #12;
    chk_digits("reset_digits", 16'h0100);
    chk_flags("reset_flags", 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic countdown from 00:03
    step(1, 0, 0, 16'h0003); chk_digits("load_0003", 16'h0003); chk_flags("load_idle", 3'b000);
    step(0, 1, 0, 16'h0);    chk_flags("start_run", 3'b100);
    step(0, 0, 1, 16'h0);    chk_digits("cd_0002", 16'h0002);
    step(0, 0, 1, 16'h0);    chk_digits("cd_0001", 16'h0001);
    step(0, 0, 1, 16'h0);    chk_digits("cd_0000", 16'h0000); chk_flags("cd_zero_run", 3'b100);
    step(0, 0, 1, 16'h0);    chk_digits("expire_hold", 16'h0000); chk_flags("expire_pulse", 3'b011);
    step(0, 0, 0, 16'h0);    chk_flags("pulse_one_cycle", 3'b010);
    step(0, 0, 1, 16'h0);    chk_digits("done_tick_ignored", 16'h0000); chk_flags("done_stays", 3'b010);
    step(0, 1, 0, 16'h0);    chk_flags("done_sp_ignored", 3'b010);

    // Borrow chain
    step(1, 0, 0, 16'h1000); chk_flags("load_leaves_done", 3'b000);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);    chk_digits("borrow_0959", 16'h0959);
    step(1, 0, 0, 16'h0010);
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0);    chk_digits("borrow_0009", 16'h0009);

    // Pause / resume
    step(1, 0, 0, 16'h0005);
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);    chk_flags("paused", 3'b000);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);    chk_digits("pause_hold", 16'h0005); chk_flags("pause_still", 3'b000);
    step(0, 1, 0, 16'h0);    chk_flags("resume", 3'b100);
    step(0, 0, 1, 16'h0);    chk_digits("resume_0004", 16'h0004);
    // Tick with start_pause in RUN: decrement then pause
    step(0, 1, 1, 16'h0);    chk_digits("sp_tick_dec", 16'h0003); chk_flags("sp_tick_pause", 3'b000);
    // Tick with start_pause in PAUSE: resume, no decrement
    step(0, 1, 1, 16'h0);    chk_digits("sp_tick_nodec", 16'h0003); chk_flags("sp_tick_resume", 3'b100);

    // Clamp and priority
    step(1, 0, 0, 16'hC379); chk_digits("clamp", 16'h9359);
    step(0, 1, 0, 16'h0);    chk_flags("clamp_run", 3'b100);
    step(1, 1, 1, 16'h0205); chk_digits("load_prio", 16'h0205); chk_flags("load_prio_idle", 3'b000);
    step(0, 0, 1, 16'h0);    chk_digits("idle_tick", 16'h0205);

    // Start on zero
    step(1, 0, 0, 16'h0000);
    step(0, 1, 0, 16'h0);    chk_flags("start_zero", 3'b000);

    // Asynchronous reset mid-run
    step(1, 0, 0, 16'h0321);
    step(0, 1, 0, 16'h0);    chk_flags("run_0321", 3'b100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_digits("async_rst_digits", 16'h0100);
    chk_flags("async_rst_flags", 3'b000);
    #5 rst_n = 1'b1;
    step(0, 0, 1, 16'h0);    chk_digits("post_rst_idle", 16'h0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Four-digit BCD MM:SS countdown timer, the down-counting, borrow-chained counterpart of the lab's BCD up-counter digits. Each digit decrements on an enable and wraps from 0 to its maximum, emitting a borrow to the next digit. A small control FSM handles load/start/pause/expiry, advancing once per external 1 Hz `tick` enable. Digit outputs feed the existing seven-segment scan logic.

Parameters:
INIT_MT, 4'd0, minutes-tens value at reset
INIT_MO, 4'd1, minutes-ones value at reset
INIT_ST, 4'd0, seconds-tens value at reset
INIT_SO, 4'd0, seconds-ones value at reset
MAX_MT, 4'd9, minutes-tens maximum (wrap/clamp value)
MAX_ST, 4'd5, seconds-tens maximum; ones digits are fixed at max 9

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle count enable (1 Hz from the frequency divider)
start_pause  input  1  debounced one-pulse; toggles run/pause
load  input  1  debounced one-pulse; loads load_* digits
load_mt, load_mo, load_st, load_so  input  4 each  values to load
mt, mo, st, so  output  4 each  current digits (registered)
running  output  1  high in RUN
expired  output  1  high in DONE
done_pulse  output  1  one-cycle pulse on RUN->DONE

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk, rising edge.
- Reset: mt/mo/st/so = INIT_MT/INIT_MO/INIT_ST/INIT_SO; state IDLE; running=0, expired=0, done_pulse=0.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Per-cycle priority: load > start_pause > tick.
- load (any state): digits <= load values, each clamped to its max (mo, so max 9; mt max MAX_MT; st max MAX_ST). State -> IDLE. Any start_pause or tick in the same cycle is ignored.
- start_pause:
  - IDLE -> RUN if digits != 00:00; if 00:00, stay IDLE.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - DONE: ignored; only load or reset leaves DONE.
- Decrement occurs only when the registered state is RUN and tick=1:
  - tick with start_pause in RUN: decrement applies, then PAUSE.
  - tick with start_pause in IDLE/PAUSE: no decrement this cycle.
- Digit rule: dec_en and value==0 -> value <= max, borrow=1; dec_en and value!=0 -> value-1, borrow=0; otherwise hold.
- Borrow chain: so dec_en = RUN&tick; st dec_en = so borrow; mo dec_en = st borrow; mt dec_en = mo borrow. All digits update in the same clock edge (zero-latency combinational borrow, registered result).
- Terminal: RUN & tick with digits == 00:00 (all zero before the tick):
  - digits held at 00:00 (no wrap to MAX);
  - state -> DONE; done_pulse=1 for exactly that next cycle.
  - The display therefore shows 00:00 for one full tick period before expiry.
- expired = (state==DONE); running = (state==RUN); all outputs registered.
- Ticks in IDLE/PAUSE/DONE are ignored. Digits never leave their legal BCD range.
- Reset asserted mid-run: immediate return to INIT values and IDLE, done_pulse cleared.

Test Plan:
- Basic countdown: load 00:03, start_pause, 4 ticks -> 00:02, 00:01, 00:00, then DONE on the 4th tick; done_pulse high exactly one cycle, expired stays 1; 5th tick -> digits unchanged at 00:00.
- Borrow chain: load 10:00, start, one tick -> 09:59. Load 00:10, one tick -> 00:09.
- Pause/resume: in RUN at 00:05, start_pause -> PAUSE; 3 ticks -> still 00:05, running=0. start_pause -> RUN; tick -> 00:04.
- Clamp and priority: load with load_st=7, load_mt=12 -> st=5, mt=9. Load asserted together with start_pause and tick in RUN -> loaded values, IDLE, no decrement.
- Start on zero and reset: load 00:00, start_pause -> stays IDLE, running=0. From RUN at 03:21, assert rst_n=0 asynchronously mid-cycle -> outputs 01:00 and IDLE immediately; running, expired, done_pulse all 0.
